// File: rtl/rti_controller.sv
// -----------------------------------------------------------------------------
// rti_controller
//
// Return-from-interrupt sequencer for the five-stage pipeline; the counterpart
// of the ICU. When decode reports an RTI, this block:
//   1. stalls the pipeline for one cycle,
//   2. pops PCH, PCL and CCR off the stack over the shared stack-control bus
//      (the reverse of the ICU push order),
//   3. redirects fetch to the restored PC and strobes the CCR reload.
//
// The stall/reg_id/stack/branch/PC bus is shared with the ICU. This block
// drives it only while it is out of IDLE and releases it (z) otherwise.
//
// Ports
//   clk_i              system clock, rising edge
//   rst_ni             asynchronous active-low reset
//   enable_i           1 = advance FSM; 0 = hold state, registers and outputs
//   rti_req_i          RTI decoded (level, sampled each enabled edge)
//   icu_busy_i         ICU currently owns the shared bus
//   pop_data_i         stack word, valid the cycle after its pop state
//   stall_o            pipeline stall                      (shared, z in IDLE)
//   reg_id_o           stack register id                   (shared, z unless popping)
//   stack_operation_o  stack access this cycle             (shared, z in IDLE)
//   push_pop_o         1 = push, 0 = pop                   (shared, z in IDLE)
//   branch_o           load pc_value_o into the PC         (shared, z in IDLE)
//   pc_value_o         restored PC {PCH, PCL}              (shared, z unless PC_CHANGE)
//   ccr_restore_o      restored CCR value
//   ccr_load_o         one-cycle strobe: load ccr_restore_o into CCR
//   rti_busy_o         high in every state except IDLE
//   rti_done_o         one-cycle pulse in PC_CHANGE
// -----------------------------------------------------------------------------
module rti_controller #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CCR_W  = 3,
  parameter logic [3:0]  PCL_ID = 4'd8,
  parameter logic [3:0]  PCH_ID = 4'd9,
  parameter logic [3:0]  CCR_ID = 4'd10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  rti_req_i,
  input  logic                  icu_busy_i,
  input  logic [DATA_W-1:0]     pop_data_i,
  output logic                  stall_o,
  output logic [3:0]            reg_id_o,
  output logic                  stack_operation_o,
  output logic                  push_pop_o,
  output logic                  branch_o,
  output logic [2*DATA_W-1:0]   pc_value_o,
  output logic [CCR_W-1:0]      ccr_restore_o,
  output logic                  ccr_load_o,
  output logic                  rti_busy_o,
  output logic                  rti_done_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STALL_1   = 3'd1,
    POP_PCH   = 3'd2,
    POP_PCL   = 3'd3,
    POP_CCR   = 3'd4,
    WAIT_DATA = 3'd5,
    PC_CHANGE = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic                pend_q,  pend_d;
  logic [DATA_W-1:0]   pch_q,   pch_d;
  logic [DATA_W-1:0]   pcl_q,   pcl_d;
  logic [CCR_W-1:0]    ccr_q,   ccr_d;

  // Decoded per-state values before the tristate release stage.
  logic                bus_en;
  logic                reg_id_en;
  logic                pc_en;
  logic                stall_v;
  logic                stack_op_v;
  logic                branch_v;
  logic [3:0]          reg_id_v;

  // ---------------------------------------------------------------------------
  // State and capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      pch_q   <= '0;
      pcl_q   <= '0;
      ccr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pch_q   <= pch_d;
      pcl_q   <= pcl_d;
      ccr_q   <= ccr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and capture logic. With enable_i low everything holds, so a
  // paused sequence resumes exactly where it stopped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pch_d   = pch_q;
    pcl_d   = pcl_q;
    ccr_d   = ccr_q;

    if (enable_i) begin
      case (state_q)
        IDLE: begin
          // The ICU has priority on a simultaneous request; remember ours in
          // pend_q and start on the first edge the ICU has let go.
          if ((rti_req_i || pend_q) && !icu_busy_i) begin
            state_d = STALL_1;
            pend_d  = 1'b0;
          end else if (rti_req_i && icu_busy_i) begin
            pend_d  = 1'b1;
          end
        end
        STALL_1:   state_d = POP_PCH;
        POP_PCH:   state_d = POP_PCL;
        // Stack data lags the pop by one cycle, so each word is captured in
        // the state after the one that requested it.
        POP_PCL: begin
          state_d = POP_CCR;
          pch_d   = pop_data_i;
        end
        POP_CCR: begin
          state_d = WAIT_DATA;
          pcl_d   = pop_data_i;
        end
        WAIT_DATA: begin
          state_d = PC_CHANGE;
          ccr_d   = pop_data_i[CCR_W-1:0];
        end
        PC_CHANGE: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (purely from the current state, so outputs hold whenever the
  // state holds and release immediately on reset).
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_en     = 1'b0;
    reg_id_en  = 1'b0;
    pc_en      = 1'b0;
    stall_v    = 1'b0;
    stack_op_v = 1'b0;
    branch_v   = 1'b0;
    reg_id_v   = 4'd0;
    ccr_load_o = 1'b0;
    rti_done_o = 1'b0;

    case (state_q)
      IDLE: ;
      STALL_1: begin
        bus_en  = 1'b1;
        stall_v = 1'b1;
      end
      POP_PCH: begin
        bus_en     = 1'b1;
        stack_op_v = 1'b1;
        reg_id_en  = 1'b1;
        reg_id_v   = PCH_ID;
      end
      POP_PCL: begin
        bus_en     = 1'b1;
        stack_op_v = 1'b1;
        reg_id_en  = 1'b1;
        reg_id_v   = PCL_ID;
      end
      POP_CCR: begin
        bus_en     = 1'b1;
        stack_op_v = 1'b1;
        reg_id_en  = 1'b1;
        reg_id_v   = CCR_ID;
      end
      WAIT_DATA: begin
        bus_en = 1'b1;
      end
      PC_CHANGE: begin
        bus_en     = 1'b1;
        branch_v   = 1'b1;
        pc_en      = 1'b1;
        ccr_load_o = 1'b1;
        rti_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared-bus drivers: released whenever this block does not own the bus so
  // the ICU can drive the same nets.
  assign stall_o           = bus_en    ? stall_v        : 1'bz;
  assign stack_operation_o = bus_en    ? stack_op_v     : 1'bz;
  assign push_pop_o        = bus_en    ? 1'b0           : 1'bz;
  assign branch_o          = bus_en    ? branch_v       : 1'bz;
  assign reg_id_o          = reg_id_en ? reg_id_v       : 4'bzzzz;
  assign pc_value_o        = pc_en     ? {pch_q, pcl_q} : {(2*DATA_W){1'bz}};

  assign ccr_restore_o = ccr_q;
  assign rti_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_rti_controller.sv
module tb_rti_controller;

  logic        clk        = 1'b0;
  logic        rst_ni     = 1'b0;
  logic        enable_i   = 1'b1;
  logic        rti_req_i  = 1'b0;
  logic        icu_busy_i = 1'b0;
  logic [15:0] pop_data_i = 16'h0000;

  wire         stall_o;
  wire  [3:0]  reg_id_o;
  wire         stack_operation_o;
  wire         push_pop_o;
  wire         branch_o;
  wire  [31:0] pc_value_o;
  wire  [2:0]  ccr_restore_o;
  wire         ccr_load_o;
  wire         rti_busy_o;
  wire         rti_done_o;

  rti_controller #(
    .DATA_W(16), .CCR_W(3), .PCL_ID(4'd8), .PCH_ID(4'd9), .CCR_ID(4'd10)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .enable_i          (enable_i),
    .rti_req_i         (rti_req_i),
    .icu_busy_i        (icu_busy_i),
    .pop_data_i        (pop_data_i),
    .stall_o           (stall_o),
    .reg_id_o          (reg_id_o),
    .stack_operation_o (stack_operation_o),
    .push_pop_o        (push_pop_o),
    .branch_o          (branch_o),
    .pc_value_o        (pc_value_o),
    .ccr_restore_o     (ccr_restore_o),
    .ccr_load_o        (ccr_load_o),
    .rti_busy_o        (rti_busy_o),
    .rti_done_o        (rti_done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ccr;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // A released net reads as all-z on a four-state simulator and as all-zero on
  // a two-state one; both mean "not driven".
  task automatic chk_rel(input string tag, input logic [31:0] obs, input int w);
    bit all_z = 1'b1;
    bit all_0 = 1'b1;
    for (int i = 0; i < w; i++) begin
      if (obs[i] !== 1'bz) all_z = 1'b0;
      if (obs[i] !== 1'b0) all_0 = 1'b0;
    end
    n_vec++;
    assert (all_z || all_0) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected released (z)", tag, obs);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs are read then.
  // The scoreboard is drained whenever the DUT signals a completed RTI.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rti_done_o === 1'b1) begin
      n_vec++;
      assert (sb_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_done: observed rti_done=1 with empty scoreboard, expected no done");
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_pc_value", pc_value_o, e.pc);
        chk("sb_ccr_restore", {29'd0, ccr_restore_o}, {29'd0, e.ccr});
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk_rel({tag, ":stall"},    {31'd0, stall_o}, 1);
    chk_rel({tag, ":reg_id"},   {28'd0, reg_id_o}, 4);
    chk_rel({tag, ":stack_op"}, {31'd0, stack_operation_o}, 1);
    chk_rel({tag, ":push_pop"}, {31'd0, push_pop_o}, 1);
    chk_rel({tag, ":branch"},   {31'd0, branch_o}, 1);
    chk_rel({tag, ":pc_value"}, pc_value_o, 32);
    chk({tag, ":rti_busy"}, {31'd0, rti_busy_o}, 32'd0);
    chk({tag, ":ccr_load"}, {31'd0, ccr_load_o}, 32'd0);
    chk({tag, ":rti_done"}, {31'd0, rti_done_o}, 32'd0);
  endtask

  task automatic check_active(input string tag, input logic stall, input logic stk,
                              input logic reg_drv, input logic [3:0] reg_id);
    chk({tag, ":stall"},    {31'd0, stall_o}, {31'd0, stall});
    chk({tag, ":stack_op"}, {31'd0, stack_operation_o}, {31'd0, stk});
    chk({tag, ":push_pop"}, {31'd0, push_pop_o}, 32'd0);
    chk({tag, ":branch"},   {31'd0, branch_o}, 32'd0);
    chk({tag, ":rti_busy"}, {31'd0, rti_busy_o}, 32'd1);
    chk({tag, ":ccr_load"}, {31'd0, ccr_load_o}, 32'd0);
    chk({tag, ":rti_done"}, {31'd0, rti_done_o}, 32'd0);
    chk_rel({tag, ":pc_value"}, pc_value_o, 32);
    if (reg_drv) chk({tag, ":reg_id"}, {28'd0, reg_id_o}, {28'd0, reg_id});
    else         chk_rel({tag, ":reg_id"}, {28'd0, reg_id_o}, 4);
  endtask

  // Entered with the DUT just in STALL_1 (cycle 1). Walks the sequence to
  // IDLE, optionally pausing hold cycles in POP_CCR.
  task automatic run_seq(input string tag, input logic [15:0] h, input logic [15:0] l,
                         input logic [15:0] c, input int hold);
    int t0;
    t0 = cyc;
    check_active({tag, ":STALL_1"}, 1'b1, 1'b0, 1'b0, 4'd0);
    pop_data_i = 16'hDEAD;
    tick();
    check_active({tag, ":POP_PCH"}, 1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    check_active({tag, ":POP_PCL"}, 1'b0, 1'b1, 1'b1, 4'd8);
    pop_data_i = h;
    tick();
    check_active({tag, ":POP_CCR"}, 1'b0, 1'b1, 1'b1, 4'd10);
    pop_data_i = l;
    if (hold > 0) begin
      enable_i = 1'b0;
      for (int k = 0; k < hold; k++) begin
        tick();
        check_active({tag, ":hold_POP_CCR"}, 1'b0, 1'b1, 1'b1, 4'd10);
      end
      enable_i = 1'b1;
    end
    tick();
    check_active({tag, ":WAIT_DATA"}, 1'b0, 1'b0, 1'b0, 4'd0);
    pop_data_i = c;
    tick();
    chk({tag, ":PC_CHANGE:branch"},   {31'd0, branch_o}, 32'd1);
    chk({tag, ":PC_CHANGE:ccr_load"}, {31'd0, ccr_load_o}, 32'd1);
    chk({tag, ":PC_CHANGE:rti_done"}, {31'd0, rti_done_o}, 32'd1);
    chk({tag, ":PC_CHANGE:stack_op"}, {31'd0, stack_operation_o}, 32'd0);
    chk({tag, ":PC_CHANGE:rti_busy"}, {31'd0, rti_busy_o}, 32'd1);
    chk_rel({tag, ":PC_CHANGE:reg_id"}, {28'd0, reg_id_o}, 4);
    chk({tag, ":latency"}, cyc - t0, 5 + hold);
    pop_data_i = 16'hBAD0;
    tick();
    check_idle({tag, ":after"});
    $display("seq %s: pch=%h pcl=%h ccr_word=%h hold=%0d", tag, h, l, c, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset and idle
    #2;
    check_idle("reset");
    chk("reset:ccr_restore", {29'd0, ccr_restore_o}, 32'd0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("idle");
    end

    // 2. Basic RTI with a one-cycle request pulse
    sb_q.push_back('{pc: 32'h0001ABCD, ccr: 3'b101});
    rti_req_i = 1'b1;
    tick();
    rti_req_i = 1'b0;
    run_seq("basic", 16'h0001, 16'hABCD, 16'h0005, 0);

    // 3. Request while the ICU owns the bus
    sb_q.push_back('{pc: 32'hCAFE0042, ccr: 3'b011});
    rti_req_i  = 1'b1;
    icu_busy_i = 1'b1;
    tick();
    rti_req_i = 1'b0;
    check_idle("icu_busy0");
    tick();
    check_idle("icu_busy1");
    tick();
    check_idle("icu_busy2");
    icu_busy_i = 1'b0;
    tick();
    run_seq("pend", 16'hCAFE, 16'h0042, 16'hFFF3, 0);
    chk("pend:ccr_hold", {29'd0, ccr_restore_o}, 32'd3);

    // 4. Asynchronous reset in the middle of POP_PCL
    rti_req_i = 1'b1;
    tick();
    rti_req_i = 1'b0;
    tick();
    tick();
    chk("rst_mid:pre_reg_id", {28'd0, reg_id_o}, 32'd8);
    pop_data_i = 16'hBEEF;
    #3;
    rst_ni = 1'b0;
    #1;
    check_idle("rst_mid");
    chk("rst_mid:ccr_restore", {29'd0, ccr_restore_o}, 32'd0);
    rst_ni = 1'b1;
    tick();
    check_idle("rst_after");
    sb_q.push_back('{pc: 32'h12345678, ccr: 3'b010});
    rti_req_i = 1'b1;
    tick();
    rti_req_i = 1'b0;
    run_seq("post_rst", 16'h1234, 16'h5678, 16'h0002, 0);

    // 5. enable low for two cycles in POP_CCR
    sb_q.push_back('{pc: 32'h00C0FFEE, ccr: 3'b111});
    rti_req_i = 1'b1;
    tick();
    rti_req_i = 1'b0;
    run_seq("enable_hold", 16'h00C0, 16'hFFEE, 16'h0007, 2);

    // 6. Request held high through the whole sequence: back-to-back RTIs
    sb_q.push_back('{pc: 32'h0F0F1111, ccr: 3'b001});
    sb_q.push_back('{pc: 32'h2222A5A5, ccr: 3'b110});
    rti_req_i = 1'b1;
    tick();
    run_seq("b2b_first", 16'h0F0F, 16'h1111, 16'h0009, 0);
    tick();
    rti_req_i = 1'b0;
    run_seq("b2b_second", 16'h2222, 16'hA5A5, 16'h0006, 0);
    tick();
    check_idle("final_idle");

    n_vec++;
    assert (sb_q.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d outstanding, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
